// File: rtl/xor_stream_cipher_pkg.sv
// rtl/xor_stream_cipher_pkg.sv - shared types and sizing helpers for xor_stream_cipher
// Contents: read-side FSM state encoding, key-byte and beat-counter sizing
// functions, constant-foldable log2.

package xor_stream_cipher_pkg;

  // Read-side packet state: no packet open, inside the clear header, past it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int key_bytes(input int key_width);
    return key_width / 8;
  endfunction

  // Number of beats touched by the clear header, i.e. where the beat counter saturates.
  function automatic int hdr_beats(input int hdr_bytes, input int beat_bytes);
    return (hdr_bytes + beat_bytes - 1) / beat_bytes;
  endfunction

  // Counter must hold 0..beats inclusive; never narrower than one bit.
  function automatic int cnt_width(input int beats);
    return (beats < 1) ? 1 : clog2(beats + 1);
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// rtl/fallthrough_small_fifo.sv - small first-word-fallthrough FIFO
// Ports: clk, reset (sync, active-high); din/wr_en write side; dout/rd_en/empty
// read side (dout valid whenever !empty); nearly_full asserts with one slot left.

module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_L  = (MAX_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NEAR_L   = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   fill;
  logic                      full;
  logic                      do_wr;
  logic                      do_rd;

  assign full        = (fill == DEPTH_L);
  assign empty       = (fill == '0);
  assign nearly_full = (fill >= NEAR_L);
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  // Head entry is presented combinationally so a beat is readable the cycle after its write.
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      fill <= fill + 1'b1;
      else if (do_rd && !do_wr) fill <= fill - 1'b1;
    end
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// rtl/xor_stream_cipher.sv - AXI4-Stream XOR cipher with clear header bytes
// Ports: axi_aclk, axi_reset (sync, active-high); s_axis_* slave stream into an
// input FIFO; m_axis_* registered master stream; cfg_enable/cfg_key latched per
// packet; stat_pkt_count counts enciphered packets emitted.
// Option: define XOR_STREAM_CIPHER_KEY_ROLL_EN to rotate the latched key left by
// one byte after every body beat.

module xor_stream_cipher
  import xor_stream_cipher_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int KEY_WIDTH            = 32,
  parameter int HDR_BYTES            = 34,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              cfg_enable,
  input  logic [KEY_WIDTH-1:0]              cfg_key,
  output logic [31:0]                       stat_pkt_count
);

  localparam int W         = C_M_AXIS_DATA_WIDTH;
  localparam int BYTES     = W / 8;
  localparam int TU        = C_M_AXIS_TUSER_WIDTH;
  localparam int FW        = W + BYTES + TU + 1;
  localparam int KEY_BYTES = key_bytes(KEY_WIDTH);
  localparam int HDR_BEATS = hdr_beats(HDR_BYTES, BYTES);
  localparam int CNT_W     = cnt_width(HDR_BEATS);
  localparam logic [CNT_W-1:0] HDR_BEATS_L = CNT_W'(HDR_BEATS);

  logic [FW-1:0]        fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_nearly_full;
  logic [W-1:0]         f_tdata;
  logic [BYTES-1:0]     f_tstrb;
  logic [TU-1:0]        f_tuser;
  logic                 f_tlast;

  logic                 load;
  logic                 rd;
  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     beat_cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 en_lat;
  logic [KEY_WIDTH-1:0] key_lat;
  logic                 eff_enable;
  logic [KEY_WIDTH-1:0] eff_key;
  logic                 out_en;
  logic [W-1:0]         xdata;
  int                   beat_base;

  // Reset gates acceptance so no beat is claimed and then flushed.
  assign s_axis_tready = !fifo_nearly_full && !axi_reset;

  fallthrough_small_fifo #(
    .WIDTH          (FW),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (axi_aclk),
    .reset       (axi_reset),
    .din         ({s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast}),
    .wr_en       (s_axis_tvalid && s_axis_tready),
    .rd_en       (rd),
    .dout        (fifo_dout),
    .empty       (fifo_empty),
    .nearly_full (fifo_nearly_full)
  );

  assign {f_tdata, f_tstrb, f_tuser, f_tlast} = fifo_dout;

  assign load = !m_axis_tvalid || m_axis_tready;
  assign rd   = !fifo_empty && load;

  // The opening beat of a packet sees live config; later beats see the latched copy.
  always_comb begin
    state_next = state;
    cnt_next   = beat_cnt;
    eff_enable = en_lat;
    eff_key    = key_lat;
    if (state == ST_IDLE) begin
      eff_enable = cfg_enable;
      eff_key    = cfg_key;
    end
    if (rd) begin
      if (f_tlast) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        if (beat_cnt < HDR_BEATS_L) cnt_next = beat_cnt + 1'b1;
        state_next = (cnt_next < HDR_BEATS_L) ? ST_HDR : ST_BODY;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= cnt_next;
    end
  end

`ifdef XOR_STREAM_CIPHER_KEY_ROLL_EN
  logic body_beat;
  assign body_beat = (beat_cnt == HDR_BEATS_L);

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      en_lat  <= 1'b0;
      key_lat <= '0;
    end else if (rd) begin
      if (state == ST_IDLE) en_lat <= cfg_enable;
      // eff_key is the live key on the opening beat, so this also restarts the rotation.
      key_lat <= body_beat ? ((eff_key << 8) | (eff_key >> (KEY_WIDTH - 8))) : eff_key;
    end
  end
`else
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      en_lat  <= 1'b0;
      key_lat <= '0;
    end else if (rd && state == ST_IDLE) begin
      en_lat  <= cfg_enable;
      key_lat <= cfg_key;
    end
  end
`endif

  // Beat widths are multiples of the key width, so the key phase of lane i is i mod KEY_BYTES
  // regardless of beat index; only the header test needs the beat's byte base.
  always_comb begin
    xdata     = f_tdata;
    beat_base = int'(beat_cnt) * BYTES;
    for (int i = 0; i < BYTES; i++) begin
      if (eff_enable && f_tstrb[BYTES-1-i] && (beat_base + i >= HDR_BYTES)) begin
        xdata[W-1-8*i -: 8] = f_tdata[W-1-8*i -: 8] ^ eff_key[KEY_WIDTH-1-8*(i % KEY_BYTES) -: 8];
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      out_en        <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= !fifo_empty;
      if (!fifo_empty) begin
        m_axis_tdata <= xdata;
        m_axis_tstrb <= f_tstrb;
        m_axis_tuser <= f_tuser;
        m_axis_tlast <= f_tlast;
        out_en       <= eff_enable;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      stat_pkt_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast && out_en) begin
      stat_pkt_count <= stat_pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// tb/tb_xor_stream_cipher.sv - self-checking bench for xor_stream_cipher (default build)

module tb_xor_stream_cipher;

  localparam int HDR = 34;

  logic         clk;
  logic         axi_reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         cfg_enable;
  logic [31:0]  cfg_key;
  logic [31:0]  stat_pkt_count;

  xor_stream_cipher #(
    .C_M_AXIS_DATA_WIDTH  (256),
    .C_S_AXIS_DATA_WIDTH  (256),
    .C_M_AXIS_TUSER_WIDTH (128),
    .C_S_AXIS_TUSER_WIDTH (128),
    .KEY_WIDTH            (32),
    .HDR_BYTES            (HDR),
    .FIFO_DEPTH_BITS      (2)
  ) dut (
    .axi_aclk       (clk),
    .axi_reset      (axi_reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .cfg_enable     (cfg_enable),
    .cfg_key        (cfg_key),
    .stat_pkt_count (stat_pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
    bit           en;
    bit           first;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_err = 0;
  int           first_seen = 0;
  int           pkts_sent = 0;
  logic [31:0]  exp_stat = 0;
  int           rdy_mode = 0;

  logic [255:0] pkt_d [32];
  logic [31:0]  pkt_s [32];
  logic [127:0] pkt_u [32];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Master ready pattern: 0 always, 1 toggle, 2 random, other = held low.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        2:       m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Scoreboard on master transfers.
  always @(negedge clk) begin
    if (!axi_reset && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 256'(1), 256'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("tdata", m_axis_tdata, mon_e.data);
        check("tstrb", 256'(m_axis_tstrb), 256'(mon_e.strb));
        check("tuser", 256'(m_axis_tuser), 256'(mon_e.user));
        check("tlast", 256'(m_axis_tlast), 256'(mon_e.last));
        if (mon_e.first) first_seen++;
        if (mon_e.last && mon_e.en) exp_stat = exp_stat + 32'd1;
      end
    end
  end

  // Reference model: byte offset within packet decides clear vs keyed; key byte by offset mod 4.
  task automatic build_packet(input int nb, input bit en, input logic [31:0] key,
                              input bit zero, input int strb_mode);
    exp_t e;
    for (int k = 0; k < nb; k++) begin
      pkt_d[k] = zero ? '0 : {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
      pkt_u[k] = zero ? '0 : {$urandom(), $urandom(), $urandom(), $urandom()};
      case (strb_mode)
        1:       pkt_s[k] = $urandom();
        2:       pkt_s[k] = (k == 1) ? 32'h3C00_0000 : 32'hFFFF_FFFF;
        default: pkt_s[k] = 32'hFFFF_FFFF;
      endcase
      e.data  = pkt_d[k];
      e.strb  = pkt_s[k];
      e.user  = pkt_u[k];
      e.last  = (k == nb - 1);
      e.en    = en;
      e.first = (k == 0);
      for (int i = 0; i < 32; i++) begin
        int off;
        off = k * 32 + i;
        if (en && pkt_s[k][31-i] && off >= HDR)
          e.data[255-8*i -: 8] = pkt_d[k][255-8*i -: 8] ^ 8'(key >> (8 * (3 - off % 4)));
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u,
                            input logic l, output int stalls);
    logic acc;
    int   budget;
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    stalls = 0;
    budget = 0;
    do begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk); #1;
      if (!acc) stalls++;
      budget++;
    end while (!acc && budget < 1000);
    if (!acc) check("accept_timeout", 256'(0), 256'(1));
  endtask

  // Config for a packet is only changed once the previous packet's first beat has left,
  // so the latch point is unambiguous while still changing config mid-packet.
  task automatic sync_cfg(input bit en, input logic [31:0] key);
    int budget;
    budget = 0;
    while (first_seen != pkts_sent && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (first_seen != pkts_sent) check("sync_timeout", 256'(first_seen), 256'(pkts_sent));
    cfg_enable = en;
    cfg_key    = key;
    pkts_sent++;
  endtask

  task automatic send_packet(input int nb, input bit en, input logic [31:0] key, input bit zero,
                             input int strb_mode, input bit gaps, output int stalls);
    int st;
    sync_cfg(en, key);
    build_packet(nb, en, key, zero, strb_mode);
    stalls = 0;
    for (int k = 0; k < nb; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      drive_beat(pkt_d[k], pkt_s[k], pkt_u[k], (k == nb - 1), st);
      stalls += st;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check(tag, 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int st;
    int lat;
    logic [255:0] rd_d;

    axi_reset     = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_enable    = 1'b0;
    cfg_key       = '0;
    repeat (3) begin @(posedge clk); #1; end
    axi_reset = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("rst_tdata", m_axis_tdata, 256'(0));
    check("rst_tlast", 256'(m_axis_tlast), 256'(0));
    check("rst_stat", 256'(stat_pkt_count), 256'(0));
    check("rst_tready", 256'(s_axis_tready), 256'(1));
    @(posedge clk); #1;

    // Latency: beat accepted at N shows on master at N+2.
    rdy_mode = 0;
    sync_cfg(1'b1, 32'h1234_5678);
    build_packet(1, 1'b1, 32'h1234_5678, 1'b0, 0);
    drive_beat(pkt_d[0], pkt_s[0], pkt_u[0], 1'b1, st);
    s_axis_tvalid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_axis_tvalid && lat < 10);
    check("latency", 256'(lat), 256'(2));
    wait_drain("drain_lat");

    // Three zero beats, key all ones: header clear, body inverted.
    send_packet(3, 1'b1, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, st);
    wait_drain("drain_ff");
    check("stat_ff", 256'(stat_pkt_count), 256'(exp_stat));

    // Bypass: identical data, count unchanged.
    send_packet(3, 1'b0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, st);
    wait_drain("drain_bypass");
    check("stat_bypass", 256'(stat_pkt_count), 256'(exp_stat));

    // Partial strobes just past the header.
    send_packet(2, 1'b1, 32'h0102_0304, 1'b1, 2, 1'b0, st);
    wait_drain("drain_strb");

    // Key changes while the first packet is still in flight.
    rdy_mode = 2;
    send_packet(4, 1'b1, 32'hAAAA_AAAA, 1'b0, 0, 1'b0, st);
    send_packet(4, 1'b1, 32'h5555_5555, 1'b0, 0, 1'b0, st);
    wait_drain("drain_keychg");
    check("stat_keychg", 256'(stat_pkt_count), 256'(exp_stat));

    // Sustained throughput with master always ready.
    rdy_mode = 0;
    @(posedge clk); #1;
    send_packet(8, 1'b1, $urandom(), 1'b0, 0, 1'b0, st);
    check("tput_stalls", 256'(st), 256'(0));
    wait_drain("drain_tput");

    // Toggling ready: FIFO must back-pressure without loss.
    rdy_mode = 1;
    send_packet(20, 1'b1, $urandom(), 1'b0, 1, 1'b0, st);
    check("backpressure_seen", 256'(st > 0), 256'(1));
    wait_drain("drain_toggle");

    // Reset mid-packet with two beats inside the block.
    rdy_mode = 3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cfg_enable = 1'b1;
    cfg_key    = $urandom();
    for (int k = 0; k < 2; k++) begin
      rd_d = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      drive_beat(rd_d, 32'hFFFF_FFFF, '0, 1'b0, st);
    end
    s_axis_tvalid = 1'b0;
    axi_reset = 1'b1;
    @(posedge clk); #1;
    axi_reset = 1'b0;
    @(negedge clk);
    check("rst_mid_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("rst_mid_stat", 256'(stat_pkt_count), 256'(0));
    exp_stat = 0;
    @(posedge clk); #1;
    rdy_mode = 0;
    // Interrupted tail arrives as its own packet starting at offset 0.
    send_packet(1, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, st);
    send_packet(3, 1'b1, 32'hC0FF_EE11, 1'b0, 0, 1'b0, st);
    wait_drain("drain_rst");
    check("stat_rst", 256'(stat_pkt_count), 256'(exp_stat));

    // Randomised traffic.
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      send_packet($urandom_range(1, 5), ($urandom_range(0, 3) != 0), $urandom(), 1'b0,
                  $urandom_range(0, 1), 1'b1, st);
    end
    wait_drain("drain_rand");
    check("stat_final", 256'(stat_pkt_count), 256'(exp_stat));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
